cp0_exception_unit: RTL and testbench
=====================================

Name: cp0_exception_unit

Overview:
- Coprocessor-0 for the pipelined MIPS core. Receives exception codes, hardware interrupts and eret from the memory stage.
- Produces the `req` (redirect to 0x0000_4180) and `epc_out` signals that the fetch unit consumes.
- Holds SR (12), Cause (13) and EPC (14), and serves mfc0/mtc0.
- Sits beside the M stage. The fetch side uses `req`/`epc_out` in the same cycle.

Parameters:
- PRID_VALUE, 32'h2023_0001, constant read from PRId (reg 15) when CP0_PRID_EN is defined.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- we  in  1  mtc0 write enable (M stage)
- cp0_addr  in  5  register number for read and write
- cp0_wdata  in  32  mtc0 data
- cp0_rdata  out  32  mfc0 data, combinational
- vpc  in  32  PC of the M-stage instruction (macro-PC)
- bd_in  in  1  M-stage instruction is in a delay slot
- exc_code_in  in  5  pipeline exception code; 0 = none
- hw_int  in  6  external interrupt lines, level-sensitive
- eret_in  in  1  M-stage instruction is eret
- req  out  1  take exception/interrupt this cycle
- epc_out  out  32  current EPC register value

Behaviour:
- Register fields:
  - SR: IM = [15:10], EXL = [1], IE = [0]. All other bits read 0.
  - Cause: BD = [31], IP = [15:10], ExcCode = [6:2]. All other bits read 0.
  - EPC: full 32 bits, bits [1:0] always stored as 0.
- Reset (clk edge with reset=1): SR, Cause and EPC all clear to 0. req = 0 while reset is high. cp0_rdata and epc_out reflect the cleared registers from the next cycle.
- int_req = |(hw_int & SR.IM) & SR.IE & !SR.EXL.
- exc_req = (exc_code_in != 0) & !SR.EXL.
- req = (int_req | exc_req) & !reset. Combinational, zero latency.
- Priority: interrupt over exception. On int_req the stored ExcCode = 0, otherwise ExcCode = exc_code_in.
- On a clock edge with req=1:
  - SR.EXL <= 1.
  - Cause.BD <= bd_in.
  - Cause.ExcCode <= selected code.
  - EPC <= (bd_in ? vpc - 4 : vpc) with bits [1:0] forced to 00.
- Cause.IP <= hw_int on every non-reset edge, independent of req/EXL.
- eret_in=1 with req=0: SR.EXL <= 0 on the edge. EPC is unchanged.
- mtc0 (we=1, req=0):
  - addr 12: SR <= wdata masked to IM/EXL/IE.
  - addr 14: EPC <= {wdata[31:2],2'b00}.
  - addr 13 and all other addresses: the write is ignored (Cause is read-only).
- Simultaneous events:
  - req and we in the same cycle: req wins, the mtc0 write is dropped.
  - req and eret_in: eret only reaches M with EXL=1, so req=0 by construction. If both are asserted anyway, req takes priority and EXL stays 1.
  - mtc0 to SR clearing EXL and eret in the same cycle: both give EXL=0.
- Reads:
  - cp0_rdata = register selected by cp0_addr (12/13/14), current register contents, no write forwarding.
  - Any other address reads 0, except addr 15 under CP0_PRID_EN.
- epc_out = EPC register. It updates the cycle after an EPC write or an exception entry.
- Nested exceptions while EXL=1 are suppressed: req=0, and EPC/ExcCode are held.

Optional Feature:
- Macro: CP0_PRID_EN.
- Defined: cp0_addr = 15 reads PRID_VALUE, and writes to it are ignored.
- Undefined: addr 15 reads 0 and no PRId logic is instantiated.

Test Plan:
1. Reset, then mtc0 SR = 32'h0000_FC01; read 12 -> 32'h0000_FC01. Read 13 -> 0, read 14 -> 0.
2. SR.IE=1, IM=6'h3F; assert hw_int[2] with vpc=32'h3010, bd_in=0 -> req=1 that cycle. Next cycle: EPC=32'h3010, ExcCode=0, EXL=1, IP[12]=1, req=0 while EXL=1.
3. EXL=0; exc_code_in=5'd4, bd_in=1, vpc=32'h3024 -> req=1. After the edge: EPC=32'h3020, Cause.BD=1, Cause[6:2]=4, epc_out=32'h3020.
4. Same cycle: exc_code_in=10, hw_int[0]=1 enabled, we=1 to addr 14 -> interrupt taken (ExcCode=0), EPC=vpc, and the mtc0 data is discarded.
5. EXL=1, eret_in=1 -> after the edge EXL=0. Then exc_code_in=12 -> req=1 again.
6. With CP0_PRID_EN: read 15 -> 32'h2023_0001, and a write to 15 is ignored. Without the macro: read 15 -> 0.

Source files
------------

// File: rtl/cp0_exception_unit_if.sv
// CP0 bus between the M stage / fetch unit (master) and CP0 (slave).
// Carries mtc0/mfc0 access, exception/interrupt inputs and redirect outputs.
interface cp0_exception_unit_if;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret_in;
  logic        req;
  logic [31:0] epc_out;

  modport master (
    output we, cp0_addr, cp0_wdata, vpc, bd_in,
    output exc_code_in, hw_int, eret_in,
    input  cp0_rdata, req, epc_out
  );

  modport slave (
    input  we, cp0_addr, cp0_wdata, vpc, bd_in,
    input  exc_code_in, hw_int, eret_in,
    output cp0_rdata, req, epc_out
  );
endinterface

// File: rtl/cp0_exception_unit.sv
// Coprocessor 0: SR(12)/Cause(13)/EPC(14), exception and interrupt entry, eret.
// Ports: clk, reset (sync, active-high), bus (cp0_exception_unit_if.slave).
// Optional CP0_PRID_EN: addr 15 reads PRID_VALUE (read-only).
module cp0_exception_unit
`ifdef CP0_PRID_EN
  #(parameter logic [31:0] PRID_VALUE = 32'h2023_0001)
`endif
(
  input logic clk,
  input logic reset,
  cp0_exception_unit_if.slave bus
);

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [29:0] epc_q, epc_d;

  logic int_req;
  logic exc_req;
  logic take;
  logic wr_sr;
  logic wr_epc;
  logic unused_vpc_lo;

  assign unused_vpc_lo = ^bus.vpc[1:0];

  assign int_req = (|(bus.hw_int & sr_im_q))
                 & sr_ie_q & ~sr_exl_q;
  assign exc_req = (bus.exc_code_in != 5'd0) & ~sr_exl_q;
  assign take    = (int_req | exc_req) & ~reset;

  assign wr_sr  = bus.we & (bus.cp0_addr == 5'd12);
  assign wr_epc = bus.we & (bus.cp0_addr == 5'd14);

  assign bus.req     = take;
  assign bus.epc_out = {epc_q, 2'b00};

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    cause_ip_d  = bus.hw_int;
    if (take) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = bus.bd_in;
      cause_exc_d = int_req ? 5'd0 : bus.exc_code_in;
      // Delay-slot faults restart at the branch, one word back.
      epc_d = bus.bd_in ? bus.vpc[31:2] - 30'd1
                        : bus.vpc[31:2];
    end else begin
      if (wr_sr) begin
        sr_im_d  = bus.cp0_wdata[15:10];
        sr_exl_d = bus.cp0_wdata[1];
        sr_ie_d  = bus.cp0_wdata[0];
      end
      if (wr_epc) begin
        epc_d = bus.cp0_wdata[31:2];
      end
      if (bus.eret_in) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    bus.cp0_rdata = 32'd0;
    case (bus.cp0_addr)
      5'd12: bus.cp0_rdata = {16'd0, sr_im_q, 8'd0,
                              sr_exl_q, sr_ie_q};
      5'd13: bus.cp0_rdata = {cause_bd_q, 15'd0, cause_ip_q,
                              3'd0, cause_exc_q, 2'b00};
      5'd14: bus.cp0_rdata = {epc_q, 2'b00};
`ifdef CP0_PRID_EN
      5'd15: bus.cp0_rdata = PRID_VALUE;
`endif
      default: bus.cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Self-checking bench for cp0_exception_unit: directed plan plus random
// traffic compared each cycle against a word-level CP0 model.
module tb_cp0_exception_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  cp0_exception_unit_if bus();

  cp0_exception_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state as architectural 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic m_int();
    return ((bus.hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    if (reset) return 1'b0;
    return m_int() || (bus.exc_code_in != 5'd0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
`ifdef CP0_PRID_EN
      5'd15: return 32'h2023_0001;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_edge();
    logic r, i;
    logic [31:0] pc;
    r = m_req();
    i = m_int();
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      if (r) begin
        m_sr[1] = 1'b1;
        m_cause[31] = bus.bd_in;
        m_cause[6:2] = i ? 5'd0 : bus.exc_code_in;
        pc = bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
        m_epc = pc & 32'hFFFF_FFFC;
      end else begin
        if (bus.we && bus.cp0_addr == 5'd12)
          m_sr = bus.cp0_wdata & 32'h0000_FC03;
        if (bus.we && bus.cp0_addr == 5'd14)
          m_epc = bus.cp0_wdata & 32'hFFFF_FFFC;
        if (bus.eret_in) m_sr[1] = 1'b0;
      end
      m_cause[15:10] = bus.hw_int;
    end
  endtask

  // Compare outputs mid-cycle, then advance DUT and model together.
  task automatic tick();
    #1;
    chk("req", {31'd0, bus.req}, {31'd0, m_req()});
    chk("rdata", bus.cp0_rdata, m_read(bus.cp0_addr));
    chk("epc_out", bus.epc_out, m_epc);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.we = 0; bus.cp0_addr = 5'd0; bus.cp0_wdata = 0;
    bus.vpc = 0; bus.bd_in = 0; bus.exc_code_in = 0;
    bus.hw_int = 0; bus.eret_in = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    bus.we = 1; bus.cp0_addr = a; bus.cp0_wdata = d;
    tick();
    idle();
  endtask

  task automatic rd(input string nm, input logic [4:0] a,
                    input logic [31:0] exp);
    bus.cp0_addr = a;
    #1;
    chk(nm, bus.cp0_rdata, exp);
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    idle();
    reset = 1;
    @(negedge clk);
    bus.exc_code_in = 5'd3;
    #1;
    chk("req_in_reset", {31'd0, bus.req}, 32'd0);
    tick();
    idle();
    tick();
    reset = 0;
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);

    // 1: SR write and reads
    mtc0(5'd12, 32'h0000_FC01);
    rd("t1_sr", 5'd12, 32'h0000_FC01);
    rd("t1_cause", 5'd13, 32'd0);
    rd("t1_epc", 5'd14, 32'd0);

    // 2: interrupt entry
    bus.hw_int = 6'b000100; bus.vpc = 32'h3010;
    #1;
    chk("t2_req", {31'd0, bus.req}, 32'd1);
    tick();
    rd("t2_epc", 5'd14, 32'h3010);
    rd("t2_cause", 5'd13, 32'h0000_1000);
    rd("t2_sr", 5'd12, 32'h0000_FC03);
    #1;
    chk("t2_req_exl", {31'd0, bus.req}, 32'd0);
    tick();
    idle();

    // 3: delay-slot exception
    mtc0(5'd12, 32'h0000_FC01);
    bus.exc_code_in = 5'd4; bus.bd_in = 1; bus.vpc = 32'h3024;
    #1;
    chk("t3_req", {31'd0, bus.req}, 32'd1);
    tick();
    idle();
    #1;
    chk("t3_epc_out", bus.epc_out, 32'h3020);
    rd("t3_cause", 5'd13, 32'h8000_0010);

    // 4: interrupt beats exception and mtc0
    mtc0(5'd12, 32'h0000_FC01);
    bus.exc_code_in = 5'd10; bus.hw_int = 6'b000001;
    bus.we = 1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'hDEAD_BEE0;
    bus.vpc = 32'h3100;
    tick();
    idle();
    #1;
    chk("t4_epc_out", bus.epc_out, 32'h3100);
    rd("t4_cause", 5'd13, 32'h0000_0400);

    // 5: eret then exception again
    bus.eret_in = 1;
    tick();
    idle();
    rd("t5_sr", 5'd12, 32'h0000_FC01);
    bus.exc_code_in = 5'd12;
    #1;
    chk("t5_req", {31'd0, bus.req}, 32'd1);
    tick();
    idle();

    // 6: PRId
`ifdef CP0_PRID_EN
    rd("t6_prid", 5'd15, 32'h2023_0001);
    mtc0(5'd15, 32'h1234_5678);
    rd("t6_prid_wr", 5'd15, 32'h2023_0001);
`else
    rd("t6_prid", 5'd15, 32'd0);
    mtc0(5'd15, 32'h1234_5678);
    rd("t6_prid_wr", 5'd15, 32'd0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      r = $urandom;
      reset = (r[5:0] == 6'd0);
      bus.we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: bus.cp0_addr = 5'd12;
        1: bus.cp0_addr = 5'd13;
        2: bus.cp0_addr = 5'd14;
        3: bus.cp0_addr = 5'd15;
        default: bus.cp0_addr = 5'($urandom);
      endcase
      bus.cp0_wdata = $urandom;
      bus.vpc = $urandom;
      bus.bd_in = r[8];
      bus.exc_code_in = ($urandom_range(0, 7) == 0)
                        ? 5'($urandom) : 5'd0;
      bus.hw_int = ($urandom_range(0, 5) == 0)
                   ? 6'($urandom) : 6'd0;
      bus.eret_in = ($urandom_range(0, 5) == 0);
      tick();
    end
    reset = 0;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
